pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter / fetch sequencer: the consumer of the ALU's doBranch output.
//  Holds the PC and steps it each cycle: +1, PC-relative branch (B/BEQ), or table branch (B_LOOKUP).
//  Runs a start/halt program handshake and counts executed instructions.
//  Sits between instruction memory (driven by prog_ctr) and the decoder/ALU, which drive its inputs.
// PARAMETERS
//  PC_W      10  width of program counter; instruction memory depth = 2**PC_W
//  LUT_IDX_W 4   index width of branch-target table; 2**LUT_IDX_W entries of PC_W bits
//  CNT_W     16  width of executed-instruction counter
// PORTS
//  clk              in   1          system clock
//  reset            in   1          synchronous, active-high reset
//  start            in   1          begin program at PC 0 (accepted in IDLE or DONE)
//  stall            in   1          hold PC/counter this cycle (multi-cycle memory op)
//  halt             in   1          decoder: instruction at prog_ctr is HALT
//  do_branch        in   1          ALU doBranch for instruction at prog_ctr
//  branch_is_lookup in   1          decoder: branch target comes from table (B_LOOKUP)
//  branch_offset    in   8          signed PC-relative offset for B/BEQ
//  lut_idx          in   LUT_IDX_W  table index for B_LOOKUP
//  lut_we           in   1          table write enable
//  lut_waddr        in   LUT_IDX_W  table write index
//  lut_wdata        in   PC_W       table write data (absolute target)
//  prog_ctr         out  PC_W       current PC, registered
//  fetch_valid      out  1          1 in RUN: instruction at prog_ctr executes this cycle
//  done             out  1          1 in DONE
//  instr_count      out  CNT_W      instructions retired since last start, saturating
// BEHAVIOUR
//  States: IDLE, RUN, DONE; all outputs registered/decoded from state.
//  Reset: state=IDLE, prog_ctr=0, instr_count=0, done=0, fetch_valid=0, all table entries=0.
//  Reset overrides everything, including mid-RUN and a same-cycle lut_we.
//  IDLE: start -> RUN with prog_ctr=0, instr_count=0; other inputs ignored.
//  RUN, stall=1: PC, counter and state hold; halt/do_branch ignored.
//  RUN, stall=0, priority order:
//   halt -> DONE; PC holds; instr_count+1.
//   do_branch & branch_is_lookup -> PC = table[lut_idx].
//   do_branch & !branch_is_lookup -> PC = PC + sext(branch_offset), mod 2**PC_W.
//   otherwise -> PC = PC + 1, mod 2**PC_W (PC 2**PC_W-1 wraps to 0).
//   instr_count increments on every non-stalled RUN cycle; saturates at all-ones.
//  Single-cycle latency: a decision in cycle N shows on prog_ctr in cycle N+1.
//  Offset is relative to the branching instruction; offset 0 branches to itself.
//  halt and do_branch together: halt wins, no branch.
//  start while in RUN: ignored.
//  DONE: done=1, fetch_valid=0, PC/count hold; start -> RUN, prog_ctr=0, instr_count=0.
//  Table: written synchronously in any state.
//   Read is combinational; a write and a lookup of the same index in one cycle return the old entry.
// STRUCTURE
//  Package pc_seq_pkg: state enum {IDLE,RUN,DONE}; PC_W/LUT_IDX_W defaults;
//   pc_t/lut_idx_t typedefs shared with decoder and instruction memory.
//  Sub-module branch_lut: 2**LUT_IDX_W x PC_W register file, 1 sync write, 1 async read, sync clear.
//  Top: state FSM, next-PC mux, saturating counter.
// TESTING
//  1 reset; start; 5 cycles with no halt or branch
//    -> prog_ctr 0,1,2,3,4; fetch_valid=1; instr_count=5.
//  2 PC=10, do_branch=1, offset=8'hFC -> prog_ctr=6 next cycle.
//    PC=6, offset=8'h00 -> stays 6.
//  3 write table[3]=10'h2A0; B_LOOKUP idx 3 -> prog_ctr=10'h2A0.
//    Same-cycle write table[5]=9 with lookup idx 5 (old entry 0) -> prog_ctr=0.
//  4 PC=1023, no branch -> PC=0. PC=1020, offset=+5 -> PC=1.
//    Force count to 16'hFFFF -> count stays 16'hFFFF.
//  5 PC=7 with halt=1 and do_branch=1 -> next cycle done=1, fetch_valid=0, prog_ctr=7.
//    Then start -> prog_ctr=0, instr_count=0, RUN.
//  6 stall=1 for 3 cycles with do_branch=1 -> PC and count unchanged.
//    Then reset mid-RUN -> IDLE, prog_ctr=0, table reads 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and default widths for the program-counter sequencer and its neighbours.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEF      = 10;
  localparam int unsigned LUT_IDX_W_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef logic [PC_W_DEF-1:0]      pc_t;
  typedef logic [LUT_IDX_W_DEF-1:0] lut_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_branch_lut.sv
// Branch-target table: one synchronous write port, one combinational read port, synchronous clear.
module branch_lut #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]      wdata,
  input  logic [LUT_IDX_W-1:0] raddr,
  output logic [PC_W-1:0]      rdata
);

  localparam int unsigned DEPTH = 2 ** LUT_IDX_W;

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] mem_d [DEPTH];

  // Read returns the stored entry, so a same-cycle write to that index is not visible yet.
  assign rdata = mem_q[raddr];

  // Next table contents: apply the single write, if any.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Table storage; reset clears every entry and beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer: start/halt handshake, next-PC selection and
// a saturating retired-instruction counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned LUT_IDX_W = LUT_IDX_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 do_branch,
  input  logic                 branch_is_lookup,
  input  logic [7:0]           branch_offset,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      prog_ctr,
  output logic                 fetch_valid,
  output logic                 done,
  output logic [CNT_W-1:0]     instr_count
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [PC_W-1:0]  lut_rdata;
  logic [PC_W-1:0]  offset_ext;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (lut_idx),
    .rdata (lut_rdata)
  );

  // Sign-extend the 8-bit relative offset to PC width; the add then wraps modulo 2**PC_W.
  assign offset_ext = PC_W'($signed(branch_offset));

  // Next state, next PC and next count; halt outranks any branch on the same instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (halt) begin
            state_d = DONE;
          end else if (do_branch && branch_is_lookup) begin
            pc_d = lut_rdata;
          end else if (do_branch) begin
            pc_d = pc_q + offset_ext;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    done_d        = (state_d == DONE);
    fetch_valid_d = (state_d == RUN);
  end

  // State, PC, counter and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign prog_ctr    = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign done        = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// against a behavioural model of the sequencer rules.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stall, halt, do_branch, branch_is_lookup, lut_we;
  logic [7:0] branch_offset;
  logic [3:0] lut_idx, lut_waddr;
  logic [9:0] lut_wdata;

  logic [9:0]  prog_ctr, prog_ctr_s;
  logic        fetch_valid, fetch_valid_s, done, done_s;
  logic [15:0] instr_count;
  logic [3:0]  instr_count_s;

  int total = 0;
  int bad   = 0;

  // Model state
  bit m_run, m_done;
  int m_pc, m_cnt, m_cnt_s;
  int m_lut [16];

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(10), .LUT_IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .do_branch(do_branch), .branch_is_lookup(branch_is_lookup),
    .branch_offset(branch_offset), .lut_idx(lut_idx), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .prog_ctr(prog_ctr),
    .fetch_valid(fetch_valid), .done(done), .instr_count(instr_count)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles.
  pc_sequencer #(.PC_W(10), .LUT_IDX_W(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .do_branch(do_branch), .branch_is_lookup(branch_is_lookup),
    .branch_offset(branch_offset), .lut_idx(lut_idx), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .prog_ctr(prog_ctr_s),
    .fetch_valid(fetch_valid_s), .done(done_s), .instr_count(instr_count_s)
  );

  task automatic clear_inputs();
    reset = 0; start = 0; stall = 0; halt = 0; do_branch = 0; branch_is_lookup = 0;
    branch_offset = 0; lut_idx = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  task automatic model_step();
    int old_entry;
    int off;
    if (reset) begin
      m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0; m_cnt_s = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      return;
    end
    old_entry = m_lut[lut_idx];
    off = int'($signed(branch_offset));
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0; m_cnt_s = 0;
      end
    end else if (!stall) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_cnt_s < 15) m_cnt_s = m_cnt_s + 1;
      if (halt) begin
        m_run = 0; m_done = 1;
      end else if (do_branch) begin
        m_pc = branch_is_lookup ? old_entry : ((m_pc + off) & 1023);
      end else begin
        m_pc = (m_pc + 1) & 1023;
      end
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  // Advance one clock: model consumes the same inputs the DUT saw, then sample 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Jump to an absolute PC through table entry 15 (must be in RUN).
  task automatic goto_pc(input int v);
    lut_we = 1; lut_waddr = 15; lut_wdata = 10'(v);
    tick();
    lut_we = 0; do_branch = 1; branch_is_lookup = 1; lut_idx = 15;
    tick();
    do_branch = 0; branch_is_lookup = 0; lut_idx = 0;
    total++; if (prog_ctr !== 10'(v)) begin bad++; $display("FAIL goto_pc: prog_ctr=%0d want %0d", prog_ctr, v); end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; start = 1; lut_we = 1; lut_waddr = 2; lut_wdata = 10'd5;
    tick();
    tick();
    clear_inputs();
    tick();
    total++; if (prog_ctr !== 10'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", prog_ctr); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", instr_count); end
  endtask

  task automatic test_sequential();
    start = 1; tick(); start = 0;
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL seq_fv: got %b want 1", fetch_valid); end
    total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL seq_cnt0: got %0d want 0", instr_count); end
    for (int i = 0; i < 5; i++) begin
      total++; if (prog_ctr !== 10'(i)) begin bad++; $display("FAIL seq_pc: got %0d want %0d", prog_ctr, i); end
      tick();
    end
    total++; if (instr_count !== 16'd5) begin bad++; $display("FAIL seq_cnt5: got %0d want 5", instr_count); end
    total++; if (prog_ctr !== 10'd5) begin bad++; $display("FAIL seq_pc5: got %0d want 5", prog_ctr); end
  endtask

  task automatic test_rel_branch();
    goto_pc(10);
    do_branch = 1; branch_offset = 8'hFC; tick();
    total++; if (prog_ctr !== 10'd6) begin bad++; $display("FAIL rel_back: got %0d want 6", prog_ctr); end
    branch_offset = 8'h00; tick();
    total++; if (prog_ctr !== 10'd6) begin bad++; $display("FAIL rel_self: got %0d want 6", prog_ctr); end
    do_branch = 0;
    total++; if (instr_count !== 16'(m_cnt)) begin bad++; $display("FAIL rel_cnt: got %0d want %0d", instr_count, m_cnt); end
  endtask

  task automatic test_lookup();
    lut_we = 1; lut_waddr = 3; lut_wdata = 10'h2A0; tick();
    lut_we = 0; do_branch = 1; branch_is_lookup = 1; lut_idx = 3; tick();
    total++; if (prog_ctr !== 10'h2A0) begin bad++; $display("FAIL lut_hit: got %h want 2a0", prog_ctr); end
    lut_we = 1; lut_waddr = 5; lut_wdata = 10'd9; lut_idx = 5; tick();
    total++; if (prog_ctr !== 10'd0) begin bad++; $display("FAIL lut_same_cycle: got %0d want 0", prog_ctr); end
    lut_we = 0; tick();
    total++; if (prog_ctr !== 10'd9) begin bad++; $display("FAIL lut_after_write: got %0d want 9", prog_ctr); end
    lut_idx = 2; tick();
    total++; if (prog_ctr !== 10'd0) begin bad++; $display("FAIL lut_reset_write: got %0d want 0", prog_ctr); end
    do_branch = 0; branch_is_lookup = 0; lut_idx = 0;
  endtask

  task automatic test_wrap();
    goto_pc(1023); tick();
    total++; if (prog_ctr !== 10'd0) begin bad++; $display("FAIL wrap_inc: got %0d want 0", prog_ctr); end
    goto_pc(1020);
    do_branch = 1; branch_offset = 8'd5; tick(); do_branch = 0;
    total++; if (prog_ctr !== 10'd1) begin bad++; $display("FAIL wrap_rel: got %0d want 1", prog_ctr); end
  endtask

  task automatic test_halt();
    goto_pc(7);
    halt = 1; do_branch = 1; branch_offset = 8'h10; tick();
    halt = 0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL halt_done: got %b want 1", done); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL halt_fv: got %b want 0", fetch_valid); end
    total++; if (prog_ctr !== 10'd7) begin bad++; $display("FAIL halt_pc: got %0d want 7", prog_ctr); end
    total++; if (instr_count !== 16'(m_cnt)) begin bad++; $display("FAIL halt_cnt: got %0d want %0d", instr_count, m_cnt); end
    tick(); do_branch = 0;
    total++; if (prog_ctr !== 10'd7 || done !== 1'b1) begin bad++; $display("FAIL done_hold: pc=%0d done=%b want 7/1", prog_ctr, done); end
    start = 1; tick(); start = 0;
    total++; if (prog_ctr !== 10'd0 || instr_count !== 16'd0) begin bad++; $display("FAIL restart: pc=%0d cnt=%0d want 0/0", prog_ctr, instr_count); end
    total++; if (fetch_valid !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL restart_flags: fv=%b done=%b want 1/0", fetch_valid, done); end
    tick(); start = 1; tick(); start = 0;
    total++; if (prog_ctr !== 10'd2) begin bad++; $display("FAIL start_in_run: got %0d want 2", prog_ctr); end
  endtask

  task automatic test_saturate();
    halt = 1; tick(); halt = 0;
    start = 1; tick(); start = 0;
    repeat (14) tick();
    total++; if (instr_count_s !== 4'd14) begin bad++; $display("FAIL sat_pre: got %0d want 14", instr_count_s); end
    tick();
    total++; if (instr_count_s !== 4'd15) begin bad++; $display("FAIL sat_reach: got %0d want 15", instr_count_s); end
    tick();
    total++; if (instr_count_s !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d want 15", instr_count_s); end
    total++; if (instr_count !== 16'd16) begin bad++; $display("FAIL sat_wide: got %0d want 16", instr_count); end
  endtask

  task automatic test_stall();
    int c0;
    goto_pc(40);
    c0 = m_cnt;
    stall = 1; do_branch = 1; branch_offset = 8'd3; halt = 1;
    repeat (3) begin
      tick();
      total++; if (prog_ctr !== 10'd40 || instr_count !== 16'(c0)) begin bad++; $display("FAIL stall_hold: pc=%0d cnt=%0d want 40/%0d", prog_ctr, instr_count, c0); end
    end
    stall = 0; halt = 0; tick(); do_branch = 0;
    total++; if (prog_ctr !== 10'd43) begin bad++; $display("FAIL stall_release: got %0d want 43", prog_ctr); end
    reset = 1; tick(); reset = 0;
    total++; if (prog_ctr !== 10'd0 || fetch_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset: pc=%0d fv=%b done=%b want 0/0/0", prog_ctr, fetch_valid, done); end
    start = 1; tick(); start = 0;
    do_branch = 1; branch_is_lookup = 1; lut_idx = 3; tick();
    do_branch = 0; branch_is_lookup = 0; lut_idx = 0;
    total++; if (prog_ctr !== 10'd0) begin bad++; $display("FAIL lut_cleared: got %0d want 0", prog_ctr); end
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = bad;
    for (int i = 0; i < 500; i++) begin
      reset            = ($urandom % 64) == 0;
      start            = ($urandom % 8) == 0;
      stall            = ($urandom % 4) == 0;
      halt             = ($urandom % 16) == 0;
      do_branch        = ($urandom % 3) == 0;
      branch_is_lookup = $urandom % 2;
      branch_offset    = 8'($urandom);
      lut_idx          = 4'($urandom);
      lut_we           = ($urandom % 3) == 0;
      lut_waddr        = 4'($urandom);
      lut_wdata        = 10'($urandom);
      tick();
      total++;
      if (prog_ctr !== 10'(m_pc) || fetch_valid !== m_run || done !== (m_done && !m_run) ||
          instr_count !== 16'(m_cnt) || instr_count_s !== 4'(m_cnt_s) || prog_ctr_s !== 10'(m_pc)) begin
        bad++;
        if (bad - errs_before <= 10)
          $display("FAIL random[%0d]: pc=%0d fv=%b done=%b cnt=%0d cnt_s=%0d want pc=%0d fv=%b done=%b cnt=%0d cnt_s=%0d",
                   i, prog_ctr, fetch_valid, done, instr_count, instr_count_s,
                   m_pc, m_run, m_done && !m_run, m_cnt, m_cnt_s);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_sequential();
    test_rel_branch();
    test_lookup();
    test_wrap();
    test_halt();
    test_saturate();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
